// File: rtl/edge_mon_pkg.sv
// Shared types and default parameters for the edge window monitor.
// rpt_t describes one window report at the default counter width.
package edge_mon_pkg;

    localparam int CNT_W_DEF       = 8;
    localparam int WINDOW_DEF      = 16;
    localparam int SYNC_STAGES_DEF = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic [CNT_W_DEF-1:0] rise;
        logic [CNT_W_DEF-1:0] fall;
        logic                 sat;
    } rpt_t;

endpackage

// File: rtl/bit_sync_filter.sv
// Multi-flop synchronizer for one asynchronous bit, with an optional
// one-cycle glitch filter selected by the GLITCH_FILTER_EN macro.
module bit_sync_filter #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_din,
    output logic o_level
);

    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_din};
        end
    end

`ifdef GLITCH_FILTER_EN
    // Follow the input only once two consecutive samples agree.
    logic r_filt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_filt <= 1'b0;
        end else if (r_sync[SYNC_STAGES-1] == r_sync[SYNC_STAGES-2]) begin
            r_filt <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_level = r_filt;
`else
    assign o_level = r_sync[SYNC_STAGES-1];
`endif

endmodule

// File: rtl/edge_window_monitor.sv
// Counts rising/falling edges of din per WINDOW cycles and reports them over
// a valid/ready port. Glitch filtering is optional (GLITCH_FILTER_EN).
//   state   | meaning
//   ST_IDLE | not counting, edge detections discarded
//   ST_RUN  | pulses emitted, edges counted per window
module edge_window_monitor
    import edge_mon_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int WINDOW      = WINDOW_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             din,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic             rpt_valid,
    input  logic             rpt_ready,
    output logic [CNT_W-1:0] rpt_rise,
    output logic [CNT_W-1:0] rpt_fall,
    output logic             rpt_sat,
    output logic             rpt_ovr
);

    localparam int               WC_W    = $clog2(WINDOW);
    localparam logic [WC_W-1:0]  WC_LAST = WC_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           r_state, w_state_nxt;
    logic             w_level, r_prev;
    logic             w_run, w_rise, w_fall, w_win_end;
    logic [WC_W-1:0]  r_wcnt;
    logic [CNT_W-1:0] r_live_rise, r_live_fall, w_rise_nxt, w_fall_nxt;
    logic             r_live_sat, w_sat_nxt;
    logic             r_rise_pulse, r_fall_pulse;
    logic             r_valid, r_ovr, r_rpt_sat;
    logic [CNT_W-1:0] r_rpt_rise, r_rpt_fall;

    bit_sync_filter #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_din   (din),
        .o_level (w_level)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (en)  w_state_nxt = ST_RUN;
            ST_RUN:  if (!en) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_run     = (r_state == ST_RUN);
    assign w_rise    = w_run & w_level & ~r_prev;
    assign w_fall    = w_run & ~w_level & r_prev;
    assign w_win_end = w_run & (r_wcnt == WC_LAST);

    // Counts including this cycle's edge, so a window-end snapshot sees it.
    always_comb begin
        w_rise_nxt = r_live_rise;
        w_fall_nxt = r_live_fall;
        w_sat_nxt  = r_live_sat;
        if (w_rise) begin
            if (r_live_rise == CNT_MAX) w_sat_nxt  = 1'b1;
            else                        w_rise_nxt = r_live_rise + 1'b1;
        end
        if (w_fall) begin
            if (r_live_fall == CNT_MAX) w_sat_nxt  = 1'b1;
            else                        w_fall_nxt = r_live_fall + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev       <= 1'b0;
            r_rise_pulse <= 1'b0;
            r_fall_pulse <= 1'b0;
        end else begin
            r_prev       <= w_level;
            r_rise_pulse <= w_rise;
            r_fall_pulse <= w_fall;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wcnt      <= '0;
            r_live_rise <= '0;
            r_live_fall <= '0;
            r_live_sat  <= 1'b0;
        end else if (clr || !w_run || w_win_end) begin
            r_wcnt      <= '0;
            r_live_rise <= '0;
            r_live_fall <= '0;
            r_live_sat  <= 1'b0;
        end else begin
            r_wcnt      <= r_wcnt + 1'b1;
            r_live_rise <= w_rise_nxt;
            r_live_fall <= w_fall_nxt;
            r_live_sat  <= w_sat_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= 1'b0;
            r_ovr      <= 1'b0;
            r_rpt_rise <= '0;
            r_rpt_fall <= '0;
            r_rpt_sat  <= 1'b0;
        end else if (clr) begin
            r_valid <= 1'b0;
            r_ovr   <= 1'b0;
        end else if (w_win_end) begin
            r_valid    <= 1'b1;
            r_rpt_rise <= w_rise_nxt;
            r_rpt_fall <= w_fall_nxt;
            r_rpt_sat  <= w_sat_nxt;
            if (r_valid && !rpt_ready) r_ovr <= 1'b1;
        end else if (r_valid && rpt_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign rise_pulse = r_rise_pulse;
    assign fall_pulse = r_fall_pulse;
    assign rpt_valid  = r_valid;
    assign rpt_ovr    = r_ovr;
    assign rpt_rise   = r_rpt_rise;
    assign rpt_fall   = r_rpt_fall;
    assign rpt_sat    = r_rpt_sat;

endmodule

// File: tb/tb_edge_window_monitor.sv
// Bench for edge_window_monitor (default build, no glitch filter): a default
// instance and a CNT_W=2 instance share stimulus and are checked every cycle.
module tb_edge_window_monitor;

    localparam int W    = 16;
    localparam int BMAX = 255;
    localparam int SMAX = 3;

    logic clk = 1'b0;
    logic rst_n, en, clr, din, rpt_ready;
    logic rise_pulse, fall_pulse, rpt_valid, rpt_sat, rpt_ovr;
    logic [7:0] rpt_rise, rpt_fall;
    logic s_rise_pulse, s_fall_pulse, s_rpt_valid, s_rpt_sat, s_rpt_ovr;
    logic [1:0] s_rpt_rise, s_rpt_fall;

    int n_chk = 0;
    int n_err = 0;
    int din_mode = 0;
    logic din_hold = 1'b0;
    int tcnt = 0;

    edge_window_monitor #(.CNT_W(8), .WINDOW(W), .SYNC_STAGES(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .din(din),
        .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
        .rpt_valid(rpt_valid), .rpt_ready(rpt_ready),
        .rpt_rise(rpt_rise), .rpt_fall(rpt_fall),
        .rpt_sat(rpt_sat), .rpt_ovr(rpt_ovr)
    );

    edge_window_monitor #(.CNT_W(2), .WINDOW(W), .SYNC_STAGES(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .din(din),
        .rise_pulse(s_rise_pulse), .fall_pulse(s_fall_pulse),
        .rpt_valid(s_rpt_valid), .rpt_ready(rpt_ready),
        .rpt_rise(s_rpt_rise), .rpt_fall(s_rpt_fall),
        .rpt_sat(s_rpt_sat), .rpt_ovr(s_rpt_ovr)
    );

    always #5 clk = ~clk;

    // din pattern generator: 0 = follow din_hold, 1 = toggle every 4, 2 = toggle every cycle
    always @(negedge clk) begin
        #2;
        case (din_mode)
            1: begin
                if (tcnt % 4 == 3) din = ~din;
                tcnt = tcnt + 1;
            end
            2: din = ~din;
            default: din = din_hold;
        endcase
    end

    // Reference model: pulses from the sampled din history, reports as sums
    // of the last W pulse slots once W run cycles have passed since restart.
    bit dq[$] = '{0, 0, 0};
    int rh[$];
    int fh[$];
    bit m_run = 0;
    int m_cnt = 0;
    int e_rise = 0, e_fall = 0, e_valid = 0, e_ovr = 0, e_rr = 0, e_rf = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dq = '{0, 0, 0};
            rh.delete();
            fh.delete();
            m_run = 0; m_cnt = 0;
            e_rise = 0; e_fall = 0; e_valid = 0; e_ovr = 0; e_rr = 0; e_rf = 0;
        end else begin
            bit win_end;
            int sr, sf;
            e_rise = (m_run && dq[1] && !dq[0]) ? 1 : 0;
            e_fall = (m_run && !dq[1] && dq[0]) ? 1 : 0;
            rh.push_back(e_rise);
            fh.push_back(e_fall);
            if (rh.size() > W) begin
                void'(rh.pop_front());
                void'(fh.pop_front());
            end
            dq.push_back(din);
            void'(dq.pop_front());
            if (m_run) m_cnt = m_cnt + 1;
            win_end = m_run && (m_cnt == W);
            if (clr) begin
                e_valid = 0;
                e_ovr   = 0;
            end else if (win_end) begin
                sr = 0; sf = 0;
                foreach (rh[i]) sr += rh[i];
                foreach (fh[i]) sf += fh[i];
                if (e_valid != 0 && !rpt_ready) e_ovr = 1;
                e_valid = 1;
                e_rr = sr;
                e_rf = sf;
            end else if (e_valid != 0 && rpt_ready) begin
                e_valid = 0;
            end
            if (clr || win_end || !en) m_cnt = 0;
            m_run = en;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int cap(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic cmp_all();
        chk("rise_pulse", rise_pulse, e_rise);
        chk("fall_pulse", fall_pulse, e_fall);
        chk("rpt_valid", rpt_valid, e_valid);
        chk("rpt_ovr", rpt_ovr, e_ovr);
        chk("s_rise_pulse", s_rise_pulse, e_rise);
        chk("s_rpt_valid", s_rpt_valid, e_valid);
        chk("s_rpt_ovr", s_rpt_ovr, e_ovr);
        if (e_valid != 0) begin
            chk("rpt_rise", rpt_rise, cap(e_rr, BMAX));
            chk("rpt_fall", rpt_fall, cap(e_rf, BMAX));
            chk("rpt_sat", rpt_sat, (e_rr > BMAX || e_rf > BMAX) ? 1 : 0);
            chk("s_rpt_rise", s_rpt_rise, cap(e_rr, SMAX));
            chk("s_rpt_fall", s_rpt_fall, cap(e_rf, SMAX));
            chk("s_rpt_sat", s_rpt_sat, (e_rr > SMAX || e_rf > SMAX) ? 1 : 0);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cmp_all();
        #1;
    endtask

    task automatic wait_rpt(output int k);
        k = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (rpt_valid) begin
                k = i;
                break;
            end
        end
        if (k == 0) chk("rpt_timeout", 0, 1);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_outs"}, {rise_pulse, fall_pulse, rpt_valid, rpt_sat, rpt_ovr, rpt_rise, rpt_fall}, 0);
        chk({nm, "_s_outs"}, {s_rise_pulse, s_fall_pulse, s_rpt_valid, s_rpt_sat, s_rpt_ovr, s_rpt_rise, s_rpt_fall}, 0);
    endtask

    initial begin
        int k;
        rst_n = 1'b0; en = 1'b0; clr = 1'b0; rpt_ready = 1'b1; din = 1'b0;
        repeat (3) tick();
        chk_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // toggle every 4 cycles, first report 17 cycles after en
        din_mode = 1;
        repeat (8) tick();
        en = 1'b1;
        wait_rpt(k);
        chk("first_rpt_latency", k, 17);
        chk("win_rise_2", rpt_rise, 2);
        chk("win_fall_2", rpt_fall, 2);
        tick();
        chk("valid_one_cycle", rpt_valid, 0);
        wait_rpt(k);
        chk("rpt_spacing", k + 1, W);

        // saturation on the 2-bit instance
        din_mode = 2;
        repeat (3) wait_rpt(k);
        chk("sat_small_rise", s_rpt_rise, 3);
        chk("sat_small_flag", s_rpt_sat, 1);
        chk("sat_big_rise", rpt_rise, 8);
        chk("sat_big_flag", rpt_sat, 0);

        // overrun: two windows without ready, second window quiet
        rpt_ready = 1'b0; clr = 1'b1;
        tick();
        clr = 1'b0;
        repeat (8) tick();
        din_mode = 0; din_hold = 1'b0;
        repeat (32) tick();
        chk("ovr_set", rpt_ovr, 1);
        chk("ovr_valid", rpt_valid, 1);
        chk("ovr_win2_rise", rpt_rise, 0);
        chk("ovr_win2_fall", rpt_fall, 0);
        rpt_ready = 1'b1;
        tick();
        chk("ovr_transfer", rpt_valid, 0);
        chk("ovr_sticky", rpt_ovr, 1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("ovr_clr", rpt_ovr, 0);

        // one-cycle glitch, no filter: one rise and one fall
        repeat (3) tick();
        din_hold = 1'b1;
        tick();
        din_hold = 1'b0;
        wait_rpt(k);
        chk("glitch_rise", rpt_rise, 1);
        chk("glitch_fall", rpt_fall, 1);

        // edge detected in the last window cycle
        clr = 1'b1;
        tick();
        clr = 1'b0;
        repeat (13) tick();
        din_hold = 1'b1;
        wait_rpt(k);
        chk("lastcyc_rise", rpt_rise, 1);
        chk("lastcyc_fall", rpt_fall, 0);
        wait_rpt(k);
        chk("next_win_rise", rpt_rise, 0);

        // clr landing on a window end suppresses the report
        repeat (15) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_at_win_end", rpt_valid, 0);
        wait_rpt(k);
        chk("restart_after_clr", k, W);

        // idle: toggling input, no pulses
        en = 1'b0; din_mode = 2;
        repeat (10) tick();
        chk("idle_no_pulse", rise_pulse | fall_pulse, 0);
        en = 1'b1;

        // mid-window reset with a pending report
        rpt_ready = 1'b0;
        wait_rpt(k);
        repeat (5) tick();
        chk("pre_reset_valid", rpt_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        repeat (3) tick();
        rst_n = 1'b1;
        rpt_ready = 1'b1;
        repeat (40) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
